core_clken_seq: RTL
===================

CORE_CLKEN_SEQ -- requirements
Module: core_clken_seq

Interface
REQ-001 Parameter LOCK_FILT, default 16, consecutive synchronized-lock cycles required before leaving WAIT_LOCK (range 1..255).
REQ-002 Parameter HOLD_CYCLES, default 1024, clk_sys cycles spent in HOLD with core_reset asserted (range 1..65535).
REQ-003 clk_sys  input  1  single clock, 28.636360 MHz PLL output; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high; the only reset.
REQ-005 pll_locked  input  1  PLL lock indication, asynchronous to clk_sys.
REQ-006 pause  input  1  synchronous; suppresses ce_cpu only.
REQ-007 core_reset  output  1  registered reset to downstream core; high until sequencing completes.
REQ-008 ce_14m  output  1  clock enable, 1 of every 2 clk_sys cycles (14.318 MHz).
REQ-009 ce_7m  output  1  clock enable, 1 of every 4 cycles (7.159 MHz pixel).
REQ-010 ce_cpu  output  1  clock enable, 1 of every 16 cycles (1.7898 MHz CPU).
REQ-011 phase  output  4  current divider phase, for downstream alignment.

Function
REQ-012 pll_locked SHALL pass through a two-flop synchronizer giving locked_s; no other logic samples pll_locked.
REQ-013 States SHALL be WAIT_LOCK, HOLD, RUN; encoding from shared package.
REQ-014 WAIT_LOCK: lock counter increments each cycle locked_s=1, clears to 0 when locked_s=0; on the cycle counter reaches LOCK_FILT, go to HOLD and clear hold counter.
REQ-015 HOLD: hold counter increments each cycle; on reaching HOLD_CYCLES go to RUN; locked_s=0 in any HOLD cycle -> WAIT_LOCK, lock counter cleared.
REQ-016 RUN: locked_s=0 -> WAIT_LOCK next edge; no other exit except reset.
REQ-017 core_reset SHALL be registered: 1 whenever state is WAIT_LOCK or HOLD, 0 in RUN; it falls on the edge that enters RUN and rises on the edge that leaves RUN.
REQ-018 phase SHALL be 0 outside RUN, increment modulo 16 each RUN cycle, first RUN cycle phase=0, wrap 15->0 without gap.
REQ-019 ce_14m = RUN & phase[0]=1; ce_7m = RUN & phase[1:0]=3; ce_cpu = RUN & phase=15 & pause=0; all single-cycle pulses, decoded from registered state/phase (no combinational path from inputs except pause->ce_cpu).
REQ-020 pause SHALL NOT stop phase, ce_14m or ce_7m; ce_cpu pulses resume at the next phase=15 after pause falls.
REQ-021 Lock loss in RUN: all ce outputs 0 and phase 0 from the edge entering WAIT_LOCK; no partial divider period is resumed.
REQ-022 Counters SHALL saturate-free: widths sized from parameters (8-bit lock, 16-bit hold); terminal compare is equality.

Reset
REQ-023 reset=1 at an edge: state WAIT_LOCK, counters 0, synchronizer flops 0, core_reset=1, phase=0, all ce=0.
REQ-024 reset mid-RUN or mid-HOLD SHALL fully restart sequencing, including lock filtering, regardless of pll_locked.

Structure
REQ-025 Package core_clk_pkg SHALL hold the state enum, PHASE_W=4, and the ce decode constants (CE_CPU_PHASE=15).
REQ-026 Synchronizer SHALL be sub-module sync_2ff (1-bit, clk and data only, no reset beyond REQ-023 clearing via reset port).

Verification (LOCK_FILT=4, HOLD_CYCLES=8)
REQ-027 Reset, pll_locked held 1 -> core_reset falls exactly 2+4+8+1=15 edges after reset release; ce_* 0 before that.
REQ-028 In RUN, 64 cycles -> ce_14m 32 pulses, ce_7m 16, ce_cpu 4 at phase=15; phase sequence 0..15 repeating.
REQ-029 pll_locked glitch 1->0 for 2 cycles during WAIT_LOCK count 3 -> counter clears; core_reset falls 15 edges after lock restored.
REQ-030 pll_locked drops in RUN -> within 3 edges core_reset=1, phase=0, ce_*=0; on relock full 15-edge sequence repeats.
REQ-031 pause=1 for cycles spanning two phase=15 -> ce_cpu absent both times, ce_14m/ce_7m unchanged; next phase=15 after release gives ce_cpu.
REQ-032 reset asserted in HOLD at hold count 5 -> WAIT_LOCK, core_reset stays 1, full sequence restarts.

Source files
------------

// File: rtl/core_clk_pkg.sv
// Shared sequencing state encoding, divider width and clock-enable decode points.
// Pure definitions; no logic, no latency.
package core_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } seq_state_t;

  localparam int PHASE_W = 4;
  localparam int LOCK_W  = 8;
  localparam int HOLD_W  = 16;

  localparam logic [PHASE_W-1:0] CE_CPU_PHASE = 4'd15;
  localparam logic [1:0]         CE_7M_PHASE  = 2'd3;

  // Divider step while running; wraps 15 -> 0 with no idle cycle.
  function automatic logic [PHASE_W-1:0] phase_step(input logic [PHASE_W-1:0] cur);
    return cur + PHASE_W'(1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Latency: 2 clk edges from d to q; no backpressure.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/core_clken_seq.sv
// PLL-lock filtered reset sequencer and /2, /4, /16 clock-enable divider for the core.
// Latency: 2-edge lock sync, LOCK_FILT+1 filter edges, HOLD_CYCLES hold edges; no backpressure.
module core_clken_seq
  import core_clk_pkg::*;
#(
  parameter int LOCK_FILT   = 16,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               pll_locked,
  input  logic               pause,
  output logic               core_reset,
  output logic               ce_14m,
  output logic               ce_7m,
  output logic               ce_cpu,
  output logic [PHASE_W-1:0] phase
);

  localparam logic [LOCK_W-1:0] LOCK_TERM = LOCK_W'(LOCK_FILT);
  localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(HOLD_CYCLES - 1);

  logic               locked_s;
  seq_state_t         state;
  seq_state_t         state_nxt;
  logic [LOCK_W-1:0]  lock_cnt;
  logic [LOCK_W-1:0]  lock_cnt_nxt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HOLD_W-1:0]  hold_cnt_nxt;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_nxt;
  logic               core_reset_q;
  logic               run;

  sync_2ff u_lock_sync (
    .clk   (clk_sys),
    .reset (reset),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state        <= WAIT_LOCK;
      lock_cnt     <= '0;
      hold_cnt     <= '0;
      phase_q      <= '0;
      core_reset_q <= 1'b1;
    end else begin
      state        <= state_nxt;
      lock_cnt     <= lock_cnt_nxt;
      hold_cnt     <= hold_cnt_nxt;
      phase_q      <= phase_nxt;
      core_reset_q <= (state_nxt != RUN);
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    hold_cnt_nxt = hold_cnt;
    case (state)
      WAIT_LOCK: begin
        if (!locked_s) begin
          lock_cnt_nxt = '0;
        end else if (lock_cnt == LOCK_TERM) begin
          // Counter already sat at LOCK_FILT for this locked cycle: lock is trusted.
          state_nxt    = HOLD;
          lock_cnt_nxt = '0;
          hold_cnt_nxt = '0;
        end else begin
          lock_cnt_nxt = lock_cnt + LOCK_W'(1);
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_nxt    = WAIT_LOCK;
          lock_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_cnt + HOLD_W'(1);
          if (hold_cnt == HOLD_TERM) begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt    = WAIT_LOCK;
          lock_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = WAIT_LOCK;
        lock_cnt_nxt = '0;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  // Phase restarts at 0 on every RUN entry so no partial divider period survives a relock.
  always_comb begin
    phase_nxt = '0;
    if (state == RUN && state_nxt == RUN) begin
      phase_nxt = phase_step(phase_q);
    end
  end

  assign run        = (state == RUN);
  assign core_reset = core_reset_q;
  assign phase      = phase_q;
  assign ce_14m     = run & phase_q[0];
  assign ce_7m      = run & (phase_q[1:0] == CE_7M_PHASE);
  assign ce_cpu     = run & (phase_q == CE_CPU_PHASE) & ~pause;

endmodule
